multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 120 ++++++++++++
 tb/tb_multicycle_controller.sv | 136 +++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle MIPS datapath
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
    MEMWB = 4'd4, MEMWR = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7,
    BRANCH = 4'd8, ADDIEXEC = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
  } state_t;
  state_t cur, nxt;
  logic pcwrite, branch, irw, mw, rw;
  assign state = cur;
  // Write enables are held off during reset so an aborted instruction leaves no side effects
  assign pcen = ~reset & (pcwrite | (branch & zero));
  assign irwrite = ~reset & irw;
  assign memwrite = ~reset & mw;
  assign regwrite = ~reset & rw;
  // State register
  always_ff @(posedge clk)
    if (reset) cur <= FETCH;
    else cur <= nxt;
  // Next-state and Moore outputs; undefined encodings fall back to FETCH with everything idle
  always_comb begin
    nxt = FETCH;
    iord = 1'b0;
    mw = 1'b0;
    irw = 1'b0;
    pcwrite = 1'b0;
    branch = 1'b0;
    rw = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    alucontrol = 3'b000;
    case (cur)
      FETCH: begin
        alusrcb = 2'b01;
        alucontrol = 3'b010;
        irw = 1'b1;
        pcwrite = 1'b1;
        nxt = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        alucontrol = 3'b010;
        nxt = (op == 6'b100011 || op == 6'b101011) ? MEMADR :
              (op == 6'b000000) ? EXECUTE :
              (op == 6'b000100) ? BRANCH :
              (op == 6'b001000) ? ADDIEXEC :
              (op == 6'b000010) ? JUMP : FETCH;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alucontrol = 3'b010;
        nxt = (op == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        nxt = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        rw = 1'b1;
      end
      MEMWR: begin
        iord = 1'b1;
        mw = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        alucontrol = (funct == 6'b100010) ? 3'b110 :
                     (funct == 6'b100100) ? 3'b000 :
                     (funct == 6'b100101) ? 3'b001 :
                     (funct == 6'b101010) ? 3'b111 : 3'b010;
        nxt = ALUWB;
      end
      ALUWB: begin
        regdst = 1'b1;
        rw = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        alucontrol = 3'b110;
        pcsrc = 2'b01;
        branch = 1'b1;
      end
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alucontrol = 3'b010;
        nxt = ADDIWB;
      end
      ADDIWB: rw = 1'b1;
      JUMP: begin
        pcsrc = 2'b10;
        pcwrite = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed scoreboard bench for multicycle_controller
module tb_multicycle_controller;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  typedef struct {
    logic [3:0]  st;
    logic [14:0] ctl;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  always #5 clk = ~clk;

  // Expected control word {iord,memwrite,irwrite,pcen,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,alucontrol}
  function automatic logic [14:0] exp_ctl(input logic [3:0] s, input logic [5:0] f, input logic z, input logic r);
    logic [14:0] c;
    logic [2:0] fa;
    fa = (f == 6'b100000) ? 3'b010 : (f == 6'b100010) ? 3'b110 : (f == 6'b100100) ? 3'b000 :
         (f == 6'b100101) ? 3'b001 : (f == 6'b101010) ? 3'b111 : 3'b010;
    case (s)
      4'd0:  c = {7'b0011000, 1'b0, 2'b01, 2'b00, 3'b010};
      4'd1:  c = {7'b0000000, 1'b0, 2'b11, 2'b00, 3'b010};
      4'd2:  c = {7'b0000000, 1'b1, 2'b10, 2'b00, 3'b010};
      4'd3:  c = {7'b1000000, 1'b0, 2'b00, 2'b00, 3'b000};
      4'd4:  c = {7'b0000101, 1'b0, 2'b00, 2'b00, 3'b000};
      4'd5:  c = {7'b1100000, 1'b0, 2'b00, 2'b00, 3'b000};
      4'd6:  c = {7'b0000000, 1'b1, 2'b00, 2'b00, fa};
      4'd7:  c = {7'b0000110, 1'b0, 2'b00, 2'b00, 3'b000};
      4'd8:  c = {3'b000, z, 3'b000, 1'b1, 2'b00, 2'b01, 3'b110};
      4'd9:  c = {7'b0000000, 1'b1, 2'b10, 2'b00, 3'b010};
      4'd10: c = {7'b0000100, 1'b0, 2'b00, 2'b00, 3'b000};
      4'd11: c = {7'b0001000, 1'b0, 2'b00, 2'b10, 3'b000};
      default: c = 15'd0;
    endcase
    if (r) begin
      c[13] = 1'b0;
      c[12] = 1'b0;
      c[11] = 1'b0;
      c[10] = 1'b0;
    end
    return c;
  endfunction

  task automatic set_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    op = o;
    funct = f;
    zero = z;
  endtask

  // Push the expectation, sample on the falling edge, then advance past the next rising edge
  task automatic step(input logic [3:0] s);
    exp_t e;
    logic [14:0] got;
    q.push_back('{st: s, ctl: exp_ctl(s, funct, zero, reset)});
    @(negedge clk);
    got = {iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc, alucontrol};
    tests++;
    assert (q.size() > 0) else begin
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      tests += 2;
      assert (state === e.st) else begin
        fails++;
        $error("FAIL state op=%b observed=%0d expected=%0d", op, state, e.st);
      end
      assert (got === e.ctl) else begin
        fails++;
        $error("FAIL ctl state=%0d op=%b observed=%b expected=%b", e.st, op, got, e.ctl);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(4'd0);
    step(4'd0);
    reset = 1'b0;
    set_instr(6'b100011, 6'd0, 1'b0);
    step(4'd0); step(4'd1); step(4'd2); step(4'd3); step(4'd4);
    set_instr(6'b101011, 6'd0, 1'b0);
    step(4'd0); step(4'd1); step(4'd2); step(4'd5);
    set_instr(6'b000000, 6'b101010, 1'b0);
    step(4'd0); step(4'd1); step(4'd6); step(4'd7);
    set_instr(6'b000000, 6'b100010, 1'b1);
    step(4'd0); step(4'd1); step(4'd6); step(4'd7);
    set_instr(6'b000000, 6'b100100, 1'b0);
    step(4'd0); step(4'd1); step(4'd6); step(4'd7);
    set_instr(6'b000000, 6'b100101, 1'b0);
    step(4'd0); step(4'd1); step(4'd6); step(4'd7);
    set_instr(6'b000000, 6'b111111, 1'b0);
    step(4'd0); step(4'd1); step(4'd6); step(4'd7);
    set_instr(6'b000100, 6'd0, 1'b1);
    step(4'd0); step(4'd1); step(4'd8);
    set_instr(6'b000100, 6'd0, 1'b0);
    step(4'd0); step(4'd1); step(4'd8);
    set_instr(6'b001000, 6'd0, 1'b0);
    step(4'd0); step(4'd1); step(4'd9); step(4'd10);
    set_instr(6'b000010, 6'd0, 1'b1);
    step(4'd0); step(4'd1); step(4'd11);
    set_instr(6'b111111, 6'd0, 1'b0);
    step(4'd0); step(4'd1);
    set_instr(6'b100011, 6'd0, 1'b0);
    step(4'd0); step(4'd1); step(4'd2);
    reset = 1'b1;
    step(4'd3);
    reset = 1'b0;
    set_instr(6'b001000, 6'd0, 1'b0);
    step(4'd0); step(4'd1); step(4'd9); step(4'd10);
    step(4'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
